// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared bus width and hold-code constants for the pipeline control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int BUSWIDTH = 32;

  // Hold codes are ordered by severity so the strongest request wins by value.
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hold_wdt.sv
// ============================================================================
// Module  : pipe_hold_wdt
// Brief   : Saturating consecutive-hold counter with a sticky timeout flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hold_wdt #(
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = $clog2(WDT_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_active,
  output logic hold_timeout
);

  localparam logic [WDT_W-1:0] c_limit = WDT_LIMIT[WDT_W-1:0];

  logic [WDT_W-1:0] r_cnt;
  logic [WDT_W-1:0] w_cnt_nxt;
  logic             r_timeout;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!hold_active)
      w_cnt_nxt = '0;
    else if (r_cnt != c_limit)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // Flag rises on the same edge the count lands on the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= r_timeout | (w_cnt_nxt == c_limit);
    end
  end

  assign hold_timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Merges jump/hold sources and sequences interrupt entry and JTAG
//           halt/resume. Optional hold watchdog under HOLD_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
`ifdef HOLD_WATCHDOG_EN
#(
  parameter int WDT_LIMIT = 1024,
  parameter int WDT_W     = $clog2(WDT_LIMIT + 1)
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_jump_flag,
  input  logic [BUSWIDTH-1:0] ex_jump_addr,
  input  logic                ex_hold_req,
  input  logic                rib_hold_req,
  input  logic                int_req,
  input  logic [BUSWIDTH-1:0] int_addr,
  input  logic                jtag_halt_req,
  output logic                int_ack,
  output logic                jump_flag,
  output logic [BUSWIDTH-1:0] jump_addr,
  output logic [2:0]          hold_flag,
  output logic                halted
`ifdef HOLD_WATCHDOG_EN
  ,
  output logic                hold_timeout
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IRQ_JUMP = 2'd1,
    ST_HALTING  = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BUSWIDTH-1:0] r_int_addr_q;
  logic                w_take_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_int_addr_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_irq)
        r_int_addr_q <= int_addr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_irq  = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = '0;
    hold_flag   = HOLD_NONE;
    int_ack     = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_RUN: begin
        jump_flag = ex_jump_flag;
        if (ex_jump_flag)
          jump_addr = ex_jump_addr;
        hold_flag = hold_max(ex_hold_req  ? HOLD_ID : HOLD_NONE,
                             rib_hold_req ? HOLD_PC : HOLD_NONE);
        // Interrupt only enters on a quiet cycle so no redirect or stall is lost.
        if (jtag_halt_req) begin
          w_state_nxt = ST_HALTING;
        end else if (int_req && !ex_jump_flag && !ex_hold_req && !rib_hold_req) begin
          w_take_irq  = 1'b1;
          w_state_nxt = ST_IRQ_JUMP;
        end
      end
      ST_IRQ_JUMP: begin
        jump_flag   = 1'b1;
        jump_addr   = r_int_addr_q;
        int_ack     = 1'b1;
        w_state_nxt = jtag_halt_req ? ST_HALTING : ST_RUN;
      end
      ST_HALTING: begin
        hold_flag = HOLD_IF;
        jump_flag = ex_jump_flag;
        if (ex_jump_flag)
          jump_addr = ex_jump_addr;
        if (!jtag_halt_req)
          w_state_nxt = ST_RUN;
        else if (!ex_hold_req && !rib_hold_req)
          w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        halted    = 1'b1;
        hold_flag = HOLD_ID;
        if (!jtag_halt_req)
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

`ifdef HOLD_WATCHDOG_EN
  logic w_hold_active;

  assign w_hold_active = (hold_flag != HOLD_NONE) && (r_state != ST_HALTED);

  pipe_hold_wdt #(
    .WDT_LIMIT (WDT_LIMIT),
    .WDT_W     (WDT_W)
  ) u_hold_wdt (
    .clk          (clk),
    .rst          (rst),
    .hold_active  (w_hold_active),
    .hold_timeout (hold_timeout)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Self-checking bench for pipe_ctrl (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ex_jump_flag = 1'b0;
  logic [BUSWIDTH-1:0] ex_jump_addr = '0;
  logic                ex_hold_req = 1'b0;
  logic                rib_hold_req = 1'b0;
  logic                int_req = 1'b0;
  logic [BUSWIDTH-1:0] int_addr = '0;
  logic                jtag_halt_req = 1'b0;
  logic                int_ack;
  logic                jump_flag;
  logic [BUSWIDTH-1:0] jump_addr;
  logic [2:0]          hold_flag;
  logic                halted;
`ifdef HOLD_WATCHDOG_EN
  logic                hold_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef HOLD_WATCHDOG_EN
  pipe_ctrl #(.WDT_LIMIT(8)) dut (
`else
  pipe_ctrl dut (
`endif
    .clk           (clk),
    .rst           (rst),
    .ex_jump_flag  (ex_jump_flag),
    .ex_jump_addr  (ex_jump_addr),
    .ex_hold_req   (ex_hold_req),
    .rib_hold_req  (rib_hold_req),
    .int_req       (int_req),
    .int_addr      (int_addr),
    .jtag_halt_req (jtag_halt_req),
    .int_ack       (int_ack),
    .jump_flag     (jump_flag),
    .jump_addr     (jump_addr),
    .hold_flag     (hold_flag),
    .halted        (halted)
`ifdef HOLD_WATCHDOG_EN
    ,
    .hold_timeout  (hold_timeout)
`endif
  );

  typedef struct {
    logic        rst;
    logic        j;
    logic [31:0] ja;
    logic        eh;
    logic        rh;
    logic        ir;
    logic [31:0] ia;
    logic        h;
    logic        ej;
    logic [31:0] ea;
    logic [2:0]  eho;
    logic        eack;
    logic        ehalt;
  } vec_t;

  typedef struct {
    int          idx;
    logic        ej;
    logic [31:0] ea;
    logic [2:0]  eho;
    logic        eack;
    logic        ehalt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic j, input logic [31:0] ja,
                     input logic eh, input logic rh, input logic ir,
                     input logic [31:0] ia, input logic h,
                     input logic ej, input logic [31:0] ea, input logic [2:0] eho,
                     input logic eack, input logic ehalt);
    vec_t v;
    v.rst = r; v.j = j; v.ja = ja; v.eh = eh; v.rh = rh; v.ir = ir; v.ia = ia; v.h = h;
    v.ej = ej; v.ea = ea; v.eho = eho; v.eack = eack; v.ehalt = ehalt;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    ex_jump_flag = 0; ex_jump_addr = '0; ex_hold_req = 0; rib_hold_req = 0;
    int_req = 0; int_addr = '0; jtag_halt_req = 0;
  endtask

  initial begin
    exp_t e;
    int   ack_cyc;
    logic [31:0] ack_addr;

    //  rst j  ja         eh rh ir ia        h   ej ea         hold       ack halt
    add(0, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);  // 0 in reset
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 1, 32'h100,   0, 0, 0, 32'h0,  0,  1, 32'h100,   HOLD_NONE, 0, 0);  // 3 same-cycle jump
    add(1, 1, 32'h200,   1, 0, 0, 32'h0,  0,  1, 32'h200,   HOLD_ID,   0, 0);
    add(1, 0, 32'h0,     0, 1, 0, 32'h0,  0,  0, 32'h0,     HOLD_PC,   0, 0);
    add(1, 0, 32'h0,     1, 1, 0, 32'h0,  0,  0, 32'h0,     HOLD_ID,   0, 0);
    add(1, 1, 32'h300,   0, 0, 1, 32'h40, 0,  1, 32'h300,   HOLD_NONE, 0, 0);  // 7 jump beats irq
    add(1, 0, 32'h0,     0, 0, 1, 32'h40, 0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 1, 32'h999,   0, 0, 1, 32'h55, 0,  1, 32'h40,    HOLD_NONE, 1, 0);  // 9 IRQ_JUMP
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     1, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_ID,   0, 0);  // 11 halt while busy
    add(1, 0, 32'h0,     1, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     1, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     1, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_ID,   0, 1);  // 16 halted
    add(1, 1, 32'h123,   0, 0, 1, 32'h80, 1,  0, 32'h0,     HOLD_ID,   0, 1);
    add(1, 0, 32'h0,     0, 0, 1, 32'h80, 0,  0, 32'h0,     HOLD_ID,   0, 1);
    add(1, 0, 32'h0,     0, 0, 1, 32'h80, 0,  0, 32'h0,     HOLD_NONE, 0, 0);  // 19 resumed
    add(1, 0, 32'h0,     0, 0, 1, 32'h80, 0,  1, 32'h80,    HOLD_NONE, 1, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 1, 0, 32'h0,  1,  0, 32'h0,     HOLD_PC,   0, 0);  // 22 halt withdrawn
    add(1, 1, 32'h444,   0, 1, 0, 32'h0,  1,  1, 32'h444,   HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 1, 0, 32'h0,  0,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 1, 0, 32'h0,  0,  0, 32'h0,     HOLD_PC,   0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'h60, 1,  0, 32'h0,     HOLD_NONE, 0, 0);  // 26 halt beats irq
    add(1, 0, 32'h0,     0, 0, 1, 32'h60, 1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'h60, 0,  0, 32'h0,     HOLD_ID,   0, 1);
    add(1, 0, 32'h0,     0, 0, 1, 32'h60, 0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'h60, 0,  1, 32'h60,    HOLD_NONE, 1, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'h70, 0,  0, 32'h0,     HOLD_NONE, 0, 0);  // 32 irq then halt
    add(1, 0, 32'h0,     0, 0, 1, 32'h70, 1,  1, 32'h70,    HOLD_NONE, 1, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  1,  0, 32'h0,     HOLD_IF,   0, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_ID,   0, 1);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'h90, 0,  0, 32'h0,     HOLD_NONE, 0, 0);  // 37 reset in IRQ_JUMP
    add(0, 0, 32'h0,     0, 0, 1, 32'h90, 0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     1, 0, 1, 32'hA0, 0,  0, 32'h0,     HOLD_ID,   0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'hA0, 0,  0, 32'h0,     HOLD_NONE, 0, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'hB0, 0,  1, 32'hA0,    HOLD_NONE, 1, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,  0,  0, 32'h0,     HOLD_NONE, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; ex_jump_flag = tbl[i].j; ex_jump_addr = tbl[i].ja;
      ex_hold_req = tbl[i].eh; rib_hold_req = tbl[i].rh; int_req = tbl[i].ir;
      int_addr = tbl[i].ia; jtag_halt_req = tbl[i].h;
      e.idx = i; e.ej = tbl[i].ej; e.ea = tbl[i].ea; e.eho = tbl[i].eho;
      e.eack = tbl[i].eack; e.ehalt = tbl[i].ehalt;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.jump_flag", e.idx), {31'd0, jump_flag}, {31'd0, e.ej});
      chk($sformatf("v%0d.jump_addr", e.idx), jump_addr, e.ea);
      chk($sformatf("v%0d.hold_flag", e.idx), {29'd0, hold_flag}, {29'd0, e.eho});
      chk($sformatf("v%0d.int_ack", e.idx), {31'd0, int_ack}, {31'd0, e.eack});
      chk($sformatf("v%0d.halted", e.idx), {31'd0, halted}, {31'd0, e.ehalt});
    end

    // Interrupt deferred by a 3-cycle execute stall; ack expected on cycle 4.
    ack_cyc  = -1;
    ack_addr = '0;
    for (int c = 0; c < 12 && ack_cyc < 0; c++) begin
      @(negedge clk);
      idle_inputs();
      int_req     = 1'b1;
      int_addr    = 32'hC0;
      ex_hold_req = (c < 3);
      #1;
      if (int_ack) begin
        ack_cyc  = c;
        ack_addr = jump_addr;
      end
    end
    @(negedge clk);
    idle_inputs();
    chk("irq_wait.ack_cycle", ack_cyc, 32'd4);
    chk("irq_wait.vector", ack_addr, 32'hC0);

`ifdef HOLD_WATCHDOG_EN
    #1;
    chk("wdt.idle", {31'd0, hold_timeout}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rib_hold_req = 1'b1;
      #1;
      if (c == 7)
        chk("wdt.before_limit", {31'd0, hold_timeout}, 32'd0);
    end
    @(negedge clk);
    rib_hold_req = 1'b0;
    #1;
    chk("wdt.at_limit", {31'd0, hold_timeout}, 32'd1);
    @(negedge clk);
    #1;
    chk("wdt.sticky", {31'd0, hold_timeout}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
